// File: rtl/demux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : demux_rr_scheduler
//  Description : Single-word buffer that sequences a 1-to-4 demux. Accepted
//                words are steered to the four channels in round-robin order
//                using sel and a one-hot out_valid. Per-channel ready applies
//                flow control, and a wrapping counter tracks deliveries.
//                Optional macro SKIP_BUSY_EN: on accept, skip over channels
//                that are not ready and choose the first ready channel,
//                starting the search at the round-robin pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_rr_scheduler #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [3:0]    ch_ready,
    output logic [3:0]    out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    sel,
    output logic [CW-1:0] deliv_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    logic [0:0]    r_state;
    logic [1:0]    r_ptr;
    logic [1:0]    r_sel;
    logic [DW-1:0] r_data;
    logic [CW-1:0] r_cnt;

    logic          w_out_fire;
    logic          w_in_ready;
    logic          w_accept;
    logic [1:0]    w_target;

    // Handshake terms. A delivery frees the buffer during the same cycle, so a
    // new word can be accepted without a bubble.
    assign w_out_fire = (r_state == S_FULL) & ch_ready[r_sel];
    assign w_in_ready = en & ((r_state == S_IDLE) | w_out_fire);
    assign w_accept   = in_valid & w_in_ready;

`ifdef SKIP_BUSY_EN
    // Target = first ready channel found by searching ptr, ptr+1, ptr+2, ptr+3.
    // The search runs from the far end back toward ptr, so the closest ready
    // channel is the one that remains. If no channel is ready, target = ptr.
    always_comb begin
        w_target = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (ch_ready[r_ptr + 2'(k)]) begin
                w_target = r_ptr + 2'(k);
            end
        end
    end
`else
    // Strict round-robin: the next word always goes to the pointer channel.
    always_comb begin
        w_target = r_ptr;
    end
`endif

    // Buffer state, steering registers and delivery counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_data  <= in_data;
                r_sel   <= w_target;
                r_ptr   <= w_target + 2'd1;
                r_state <= S_FULL;
            end else if (w_out_fire) begin
                r_state <= S_IDLE;
            end
            if (w_out_fire) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == S_FULL) ? (4'b0001 << r_sel) : 4'b0000;
    assign out_data  = r_data;
    assign sel       = r_sel;
    assign deliv_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_rr_scheduler
//  Description : Directed bench for demux_rr_scheduler, with hand-computed
//                expected values. A second instance with CW=4 shares all
//                inputs so the counter wrap can be observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] ch_ready;

    logic        in_ready,  in_ready4;
    logic [3:0]  out_valid, out_valid4;
    logic [7:0]  out_data,  out_data4;
    logic [1:0]  sel,       sel4;
    logic [15:0] deliv_cnt;
    logic [3:0]  deliv_cnt4;

    int total = 0;
    int bad   = 0;

    demux_rr_scheduler #(.DW(8), .CW(16)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ch_ready(ch_ready), .out_valid(out_valid),
        .out_data(out_data), .sel(sel), .deliv_cnt(deliv_cnt)
    );

    demux_rr_scheduler #(.DW(8), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .ch_ready(ch_ready), .out_valid(out_valid4),
        .out_data(out_data4), .sel(sel4), .deliv_cnt(deliv_cnt4)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] words [5];

    initial begin
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;

        // ---- Reset state ----
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = 8'h00; ch_ready = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_sel",       32'(sel),       32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_deliv",     32'(deliv_cnt), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);

        // ---- 1: back-to-back words, round-robin order ----
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = words[i];
            tick();
            chk("t1_out_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
            chk("t1_out_data",  32'(out_data),  32'(words[i]));
            chk("t1_deliv",     32'(deliv_cnt), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("t1_idle_valid", 32'(out_valid), 32'h0);
        chk("t1_deliv_end",  32'(deliv_cnt), 32'd5);

        // ---- 2: channel 1 stalls for 3 cycles while word 22 is held (ptr=1) ----
        in_valid = 1'b1; in_data = 8'h22; ch_ready = 4'b1101;
        tick();
        chk("t2_hold0_valid", 32'(out_valid), 32'b0010);
        chk("t2_hold0_ready", 32'(in_ready),  32'h0);
        in_data = 8'h33;
        for (int i = 1; i < 3; i++) begin
            tick();
            chk("t2_hold_valid", 32'(out_valid), 32'b0010);
            chk("t2_hold_data",  32'(out_data),  32'h22);
            chk("t2_hold_ready", 32'(in_ready),  32'h0);
            chk("t2_hold_deliv", 32'(deliv_cnt), 32'd5);
        end
        ch_ready = 4'b1111;
        #1;
        chk("t2_release_ready", 32'(in_ready),  32'h1);
        chk("t2_release_valid", 32'(out_valid), 32'b0010);
        tick();
        chk("t2_next_valid", 32'(out_valid), 32'b0100);
        chk("t2_next_data",  32'(out_data),  32'h33);
        chk("t2_next_deliv", 32'(deliv_cnt), 32'd6);

        // ---- 3: en=0 while word 44 is held; it still drains, then nothing is accepted ----
        in_data = 8'h44;
        tick();
        chk("t3_44_valid", 32'(out_valid), 32'b1000);
        chk("t3_44_deliv", 32'(deliv_cnt), 32'd7);
        en = 1'b0; ch_ready = 4'b0111; in_data = 8'h55;
        #1;
        chk("t3_en0_ready", 32'(in_ready), 32'h0);
        tick();
        chk("t3_held_valid", 32'(out_valid), 32'b1000);
        chk("t3_held_data",  32'(out_data),  32'h44);
        ch_ready = 4'b1111;
        tick();
        chk("t3_drain_valid", 32'(out_valid), 32'h0);
        chk("t3_drain_deliv", 32'(deliv_cnt), 32'd8);
        chk("t3_drain_ready", 32'(in_ready),  32'h0);
        tick();
        chk("t3_stay_valid", 32'(out_valid), 32'h0);
        chk("t3_stay_deliv", 32'(deliv_cnt), 32'd8);

        // ---- 4: reset while FULL (ptr=0 -> 66 to ch0, 77 held on ch1) ----
        en = 1'b1; in_data = 8'h66;
        tick();
        chk("t4_66_sel", 32'(sel), 32'd0);
        in_data = 8'h77;
        tick();
        ch_ready = 4'b0000; in_valid = 1'b0;
        tick();
        chk("t4_77_valid", 32'(out_valid), 32'b0010);
        chk("t4_77_deliv", 32'(deliv_cnt), 32'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_valid", 32'(out_valid), 32'h0);
        chk("t4_rst_sel",   32'(sel),       32'h0);
        chk("t4_rst_deliv", 32'(deliv_cnt), 32'h0);
        chk("t4_rst_data",  32'(out_data),  32'h0);
        ch_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h88;
        tick();
        chk("t4_88_valid", 32'(out_valid), 32'b0001);
        chk("t4_88_data",  32'(out_data),  32'h88);
        in_data = 8'h99;
        tick();
        chk("t4_99_sel", 32'(sel), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("t4_deliv", 32'(deliv_cnt), 32'd2);

        // ---- 5: ptr=2 with ch_ready=1011 ----
        ch_ready = 4'b1011; in_valid = 1'b1; in_data = 8'hAA;
        tick();
        in_valid = 1'b0;
`ifdef SKIP_BUSY_EN
        chk("t5_sel",   32'(sel),       32'd3);
        chk("t5_valid", 32'(out_valid), 32'b1000);
        tick();
        chk("t5_drain_valid", 32'(out_valid), 32'h0);
`else
        chk("t5_sel",   32'(sel),       32'd2);
        chk("t5_valid", 32'(out_valid), 32'b0100);
        tick();
        chk("t5_wait_valid", 32'(out_valid), 32'b0100);
        chk("t5_wait_data",  32'(out_data),  32'hAA);
`endif
        ch_ready = 4'b1111;
        tick();
        chk("t5_idle_valid", 32'(out_valid), 32'h0);
        chk("t5_deliv",      32'(deliv_cnt), 32'd3);
        in_valid = 1'b1; in_data = 8'hBB;
        tick();
        in_valid = 1'b0;
`ifdef SKIP_BUSY_EN
        chk("t5_next_sel", 32'(sel), 32'd0);
`else
        chk("t5_next_sel", 32'(sel), 32'd3);
`endif
        tick();

        // ---- 6: counter wrap on the CW=4 instance ----
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(i);
            tick();
            chk("t6_sel", 32'(sel), 32'(i % 4));
        end
        chk("t6_wrap_cnt4", 32'(deliv_cnt4), 32'd0);
        chk("t6_cnt16",     32'(deliv_cnt),  32'd16);
        in_valid = 1'b0;
        tick();
        chk("t6_17_cnt4", 32'(deliv_cnt4), 32'd1);
        chk("t6_17_cnt16", 32'(deliv_cnt), 32'd17);
        chk("t6_idle",    32'(out_valid4), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
